binary_thresholder: RTL and testbench
=====================================

BINARY_THRESHOLDER -- requirements
Module: binary_thresholder

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 480, lines per frame; TOTAL = IMG_WIDTH*IMG_HEIGHT.
REQ-003 Parameter DEFAULT_THRESH, default 128, threshold value after reset.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 x_valid / x_ready / x_data  in / out / in  1/1/8  input grayscale pixel stream; transfer when x_valid && x_ready.
REQ-007 x_sof  in  1  high with the first pixel of a frame; qualified by the input transfer.
REQ-008 y_valid / y_ready / y_data  out / in / out  1/1/8  binary output stream; y_data is 0 or 255 only.
REQ-009 y_sof, y_eof  out  1 each  first-pixel / last-pixel (index TOTAL-1) markers, aligned with y_data.
REQ-010 thresh_in  in  8  new threshold value; thresh_load  in  1  one-cycle strobe capturing thresh_in.
REQ-011 invert  in  1  swaps output polarity; sampled with the threshold (REQ-016).
REQ-012 white_count  out  $clog2(TOTAL+1)  number of 255 pixels in the last completed frame.
REQ-013 count_valid  out  1  one-cycle pulse when white_count updates.
REQ-014 frame_error  out  1  one-cycle pulse on a framing violation.

Function
REQ-015 Binarization: y_data = 255 when x_data >= active_thresh, else 0; when active_invert = 1 the result is swapped.
REQ-016 thresh_load writes pending_thresh/pending_invert; copied to active_thresh/active_invert only on an accepted x_sof pixel, which itself uses the new values; no mid-frame change.
REQ-017 Output register: latency 1 cycle from input transfer to y_valid; x_ready = !y_valid || y_ready; full throughput of 1 pixel/cycle under continuous y_ready.
REQ-018 y_data, y_sof, y_eof shall hold stable while y_valid && !y_ready.
REQ-019 State SYNC: x_ready follows REQ-017; pixels with x_sof = 0 are accepted and dropped (no output); accepted x_sof pixel -> emit as pixel 0 with y_sof = 1, pix_cnt = 1, go ACTIVE.
REQ-020 State ACTIVE: each accepted pixel is emitted, pix_cnt increments; pixel with pix_cnt = TOTAL-1 is emitted with y_eof = 1, then state -> SYNC, pix_cnt -> 0.
REQ-021 x_sof on an accepted pixel in ACTIVE (early frame): frame_error pulses, white accumulator clears, that pixel is emitted as new pixel 0 with y_sof = 1, pix_cnt = 1, state stays ACTIVE; no count_valid for the aborted frame.
REQ-022 x_sof on the pixel that is index TOTAL-1 is treated as REQ-021 (error takes priority over eof).
REQ-023 If TOTAL = 1, a single x_sof pixel carries both y_sof and y_eof.
REQ-024 White accumulator counts emitted 255 pixels; on the y_eof pixel's input transfer white_count <= accumulator + (this pixel white), count_valid pulses next cycle, accumulator clears.
REQ-025 Simultaneous thresh_load and accepted x_sof: the sof pixel uses the previous pending value; new value applies at the following frame.

Reset
REQ-026 On rst_n low: state SYNC, pix_cnt 0, y_valid 0, y_sof 0, y_eof 0, y_data 0, white_count 0, count_valid 0, frame_error 0, accumulator 0, pending/active thresh = DEFAULT_THRESH, pending/active invert 0.
REQ-027 Reset mid-frame discards the frame and any held output; after release the block waits for x_sof.

Verification
REQ-028 IMG 4x2, thresh 128, y_ready=1, frame x_sof + data 0,127,128,255,200,10,128,129 -> y_data 0,0,255,255,255,0,255,255; y_sof on 1st, y_eof on 8th, white_count=5, count_valid pulse once.
REQ-029 Three pixels without x_sof then valid frame -> first three dropped, no output, output frame identical to REQ-028.
REQ-030 y_ready toggled 1010... during frame -> no pixel lost/duplicated, outputs stable while stalled, x_ready low while y_valid && !y_ready.
REQ-031 x_sof at pixel 5 of 8 -> frame_error pulse, new y_sof on that pixel, no count_valid until 8 pixels later.
REQ-032 thresh_load 200 with invert=1 mid-frame -> current frame unchanged; next frame pixel 210 -> 0, 100 -> 255.
REQ-033 rst_n asserted at pixel 4 -> all outputs at REQ-026 values immediately; post-release non-sof pixels dropped.

Source files
------------

// File: rtl/binary_thresholder.sv
// Streaming grayscale-to-binary thresholder with frame tracking, double-buffered
// threshold/polarity, and per-frame white-pixel count.
module binary_thresholder #(
   parameter int IMG_WIDTH      = 640,
   parameter int IMG_HEIGHT     = 480,
   parameter int DEFAULT_THRESH = 128
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         x_valid,
   output logic                                         x_ready,
   input  logic [7:0]                                   x_data,
   input  logic                                         x_sof,
   output logic                                         y_valid,
   input  logic                                         y_ready,
   output logic [7:0]                                   y_data,
   output logic                                         y_sof,
   output logic                                         y_eof,
   input  logic [7:0]                                   thresh_in,
   input  logic                                         thresh_load,
   input  logic                                         invert,
   output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0]    white_count,
   output logic                                         count_valid,
   output logic                                         frame_error
);

   localparam int                TOTAL    = IMG_WIDTH * IMG_HEIGHT;
   localparam int                CNT_W    = $clog2(TOTAL + 1);
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(TOTAL - 1);
   localparam logic [7:0]        THR_RST  = 8'(DEFAULT_THRESH);

   typedef enum logic {S_SYNC, S_ACTIVE} state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_acc;
   logic [CNT_W-1:0]  w_acc_sum;
   logic [7:0]        r_pend_thr, r_act_thr, w_thr;
   logic              r_pend_inv, r_act_inv, w_inv;
   logic              w_xfer, w_emit, w_sof, w_eof, w_err, w_white;

   function automatic logic binarize(input logic [7:0] pix, input logic [7:0] thr,
                                     input logic inv);
      return (pix >= thr) ^ inv;
   endfunction

   assign x_ready = !y_valid || y_ready;
   assign w_xfer  = x_valid && x_ready;

   // A start-of-frame pixel already uses the pending settings it is about to activate
   assign w_thr     = (w_xfer && x_sof) ? r_pend_thr : r_act_thr;
   assign w_inv     = (w_xfer && x_sof) ? r_pend_inv : r_act_inv;
   assign w_white   = binarize(x_data, w_thr, w_inv);
   assign w_acc_sum = (w_sof ? '0 : r_acc) + CNT_W'(w_white);

   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      w_sof       = 1'b0;
      w_eof       = 1'b0;
      w_err       = 1'b0;
      if (w_xfer) begin
         if (x_sof) begin
            w_emit = 1'b1;
            w_sof  = 1'b1;
            w_err  = (r_state == S_ACTIVE);
            if (TOTAL == 1) begin
               w_eof       = 1'b1;
               w_state_nxt = S_SYNC;
            end else begin
               w_state_nxt = S_ACTIVE;
            end
         end else if (r_state == S_ACTIVE) begin
            w_emit = 1'b1;
            if (r_cnt == LAST_IDX) begin
               w_eof       = 1'b1;
               w_state_nxt = S_SYNC;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_SYNC;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_acc       <= '0;
         r_pend_thr  <= THR_RST;
         r_pend_inv  <= 1'b0;
         r_act_thr   <= THR_RST;
         r_act_inv   <= 1'b0;
         y_valid     <= 1'b0;
         y_data      <= 8'd0;
         y_sof       <= 1'b0;
         y_eof       <= 1'b0;
         white_count <= '0;
         count_valid <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         count_valid <= 1'b0;
         frame_error <= w_err;
         if (thresh_load) begin
            r_pend_thr <= thresh_in;
            r_pend_inv <= invert;
         end
         if (w_xfer) begin
            y_valid <= w_emit;
            y_sof   <= w_sof;
            y_eof   <= w_eof;
            if (w_emit) y_data <= {8{w_white}};
            if (x_sof) begin
               r_act_thr <= r_pend_thr;
               r_act_inv <= r_pend_inv;
            end
            if (w_eof)       r_cnt <= '0;
            else if (w_sof)  r_cnt <= CNT_W'(1);
            else if (w_emit) r_cnt <= r_cnt + CNT_W'(1);
            if (w_eof) begin
               white_count <= w_acc_sum;
               count_valid <= 1'b1;
               r_acc       <= '0;
            end else if (w_emit) begin
               r_acc <= w_acc_sum;
            end
         end else if (y_ready) begin
            y_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_binary_thresholder.sv
// Randomized and directed bench for binary_thresholder (4x2 image) against a
// frame-level reference model with a single-slot output scoreboard.
module tb_binary_thresholder;
   localparam int W     = 4;
   localparam int H     = 2;
   localparam int TOTAL = W * H;
   localparam int CW    = $clog2(TOTAL + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          x_valid = 1'b0, x_sof = 1'b0, y_ready = 1'b0;
   logic          thresh_load = 1'b0, invert = 1'b0;
   logic [7:0]    x_data = 8'd0, thresh_in = 8'd0;
   logic          x_ready, y_valid, y_sof, y_eof, count_valid, frame_error;
   logic [7:0]    y_data;
   logic [CW-1:0] white_count;

   always #5 clk = ~clk;

   binary_thresholder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DEFAULT_THRESH(128)) dut (
      .clk(clk), .rst_n(rst_n),
      .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_sof(x_sof),
      .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_sof(y_sof), .y_eof(y_eof),
      .thresh_in(thresh_in), .thresh_load(thresh_load), .invert(invert),
      .white_count(white_count), .count_valid(count_valid), .frame_error(frame_error));

   typedef struct {
      logic [7:0] d;
      logic       s;
      logic       e;
   } item_t;

   int         n_cmp = 0, n_fail = 0;
   item_t      q[$];
   int         m_idx = -1, m_acc = 0, m_wc = 0;
   logic [7:0] m_pthr = 8'd128, m_athr = 8'd128;
   logic       m_pinv = 1'b0, m_ainv = 1'b0;
   bit         m_cv = 0, m_fe = 0;
   logic [7:0] got[$];
   int         cv_seen = 0, fe_seen = 0;
   bit         g_acc = 0;
   int         rdy_mode = 0;
   bit         rdy_tgl = 0;
   bit         g_ld = 0;
   logic [7:0] g_ti = 8'd0;
   bit         g_inv = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_accept();
      bit    emit = 0, sof = 0, white;
      item_t it;
      if (x_sof) begin
         m_fe   = (m_idx >= 0);
         m_athr = m_pthr;
         m_ainv = m_pinv;
         m_idx  = 0;
         m_acc  = 0;
         emit   = 1;
         sof    = 1;
      end else if (m_idx >= 0) begin
         emit = 1;
      end
      if (emit) begin
         white = (x_data >= m_athr) ^ m_ainv;
         m_acc += int'(white);
         it.d = white ? 8'd255 : 8'd0;
         it.s = sof;
         it.e = (m_idx == TOTAL - 1);
         q.push_back(it);
         if (it.e) begin
            m_cv  = 1;
            m_wc  = m_acc;
            m_idx = -1;
            m_acc = 0;
         end else begin
            m_idx++;
         end
      end
   endtask

   task automatic check_and_model();
      bit exp_rdy;
      chk("y_valid", y_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk("y_data", y_data, q[0].d);
         chk("y_sof", y_sof, q[0].s);
         chk("y_eof", y_eof, q[0].e);
      end
      chk("count_valid", count_valid, m_cv);
      chk("white_count", white_count, m_wc);
      chk("frame_error", frame_error, m_fe);
      if (count_valid) cv_seen++;
      if (frame_error) fe_seen++;
      m_cv = 0;
      m_fe = 0;
      exp_rdy = (q.size() == 0) || y_ready;
      chk("x_ready", x_ready, exp_rdy);
      if (q.size() != 0 && y_ready) begin
         got.push_back(y_data);
         void'(q.pop_front());
      end
      g_acc = x_valid && exp_rdy;
      if (g_acc) model_accept();
      if (thresh_load) begin
         m_pthr = thresh_in;
         m_pinv = invert;
      end
   endtask

   task automatic step(input bit v, input bit s, input logic [7:0] d);
      @(negedge clk);
      rdy_tgl = ~rdy_tgl;
      x_valid = v;
      x_sof   = s;
      x_data  = d;
      case (rdy_mode)
         0:       y_ready = 1'b1;
         1:       y_ready = rdy_tgl;
         default: y_ready = 1'($urandom_range(0, 1));
      endcase
      thresh_load = g_ld;
      thresh_in   = g_ti;
      invert      = g_inv;
      #1;
      check_and_model();
      g_ld = 0;
   endtask

   task automatic send_pix(input bit s, input logic [7:0] d);
      int n = 0;
      g_acc = 0;
      while (!g_acc && n < 50) begin
         step(1'b1, s, d);
         n++;
      end
      if (!g_acc) begin
         n_cmp++;
         n_fail++;
         $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
      end
   endtask

   task automatic drain();
      int n = 0;
      rdy_mode = 0;
      while ((q.size() != 0 || n < 2) && n < 50) begin
         step(1'b0, 1'b0, 8'd0);
         n++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_y_valid"}, y_valid, 1'b0);
      chk({tag, "_y_sof"}, y_sof, 1'b0);
      chk({tag, "_y_eof"}, y_eof, 1'b0);
      chk({tag, "_y_data"}, y_data, 8'd0);
      chk({tag, "_white_count"}, white_count, 0);
      chk({tag, "_count_valid"}, count_valid, 1'b0);
      chk({tag, "_frame_error"}, frame_error, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      x_valid = 1'b0;
      thresh_load = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst");
      q.delete();
      m_idx = -1; m_acc = 0; m_wc = 0; m_cv = 0; m_fe = 0;
      m_pthr = 8'd128; m_athr = 8'd128; m_pinv = 0; m_ainv = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [7:0] f28_in  [8] = '{8'd0, 8'd127, 8'd128, 8'd255, 8'd200, 8'd10, 8'd128, 8'd129};
   logic [7:0] f28_out [8] = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255};

   task automatic send_f28();
      for (int i = 0; i < 8; i++) send_pix(i == 0, f28_in[i]);
   endtask

   task automatic check_f28(input string tag);
      chk({tag, "_count"}, got.size(), 8);
      for (int i = 0; i < 8 && i < got.size(); i++) chk({tag, "_pix"}, got[i], f28_out[i]);
   endtask

   initial begin
      int cv0, fe0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("init");
      chk("init_x_ready", x_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // basic frame
      got.delete(); cv0 = cv_seen;
      send_f28();
      drain();
      check_f28("f28");
      chk("f28_white_count", white_count, 5);
      chk("f28_cv_pulses", cv_seen - cv0, 1);

      // junk before sof is dropped
      got.delete();
      for (int i = 0; i < 3; i++) send_pix(1'b0, 8'd250);
      send_f28();
      drain();
      check_f28("f29");

      // backpressure toggling
      got.delete(); rdy_mode = 1;
      send_f28();
      drain();
      check_f28("f30");

      // early sof at pixel 5
      got.delete(); cv0 = cv_seen; fe0 = fe_seen;
      for (int i = 0; i < 4; i++) send_pix(i == 0, 8'd200);
      chk("f31_cv_before", cv_seen - cv0, 0);
      for (int i = 0; i < 8; i++) send_pix(i == 0, 8'd50);
      drain();
      chk("f31_fe_pulses", fe_seen - fe0, 1);
      chk("f31_cv_pulses", cv_seen - cv0, 1);
      chk("f31_out_count", got.size(), 12);
      chk("f31_white_count", white_count, 0);

      // threshold change mid-frame applies next frame
      got.delete();
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin g_ld = 1; g_ti = 8'd200; g_inv = 1; end
         send_pix(i == 0, 8'd150);
      end
      send_pix(1'b1, 8'd210);
      send_pix(1'b0, 8'd100);
      for (int i = 2; i < 8; i++) send_pix(1'b0, 8'd0);
      drain();
      chk("f32_cur_frame", got[5], 8'd255);
      chk("f32_next_210", got[8], 8'd0);
      chk("f32_next_100", got[9], 8'd255);
      do_reset();

      // reset mid-frame
      for (int i = 0; i < 4; i++) send_pix(i == 0, 8'd200);
      do_reset();
      got.delete();
      for (int i = 0; i < 3; i++) send_pix(1'b0, 8'd255);
      drain();
      chk("f33_dropped", got.size(), 0);
      send_f28();
      drain();
      check_f28("f33");

      // randomized traffic
      for (int f = 0; f < 40; f++) begin
         int len;
         rdy_mode = 2;
         if ($urandom_range(0, 3) == 0) send_pix(1'b0, 8'($urandom));
         len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, TOTAL - 1)) : TOTAL;
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 9) == 0) begin
               g_ld = 1; g_ti = 8'($urandom); g_inv = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 4) == 0) step(1'b0, 1'b0, 8'd0);
            send_pix(i == 0, 8'($urandom));
         end
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
